wb_efuse_loader: RTL

Wishbone initiator that copies the eFuse array into on-chip shadow registers at power-up and on request. It is the master-side counterpart of the eFuse Wishbone responder and drives the same classic single-transfer Wishbone read cycles. It presents the fetched words as a flat, static configuration bus with a valid flag, so trim and ID logic never has to issue bus transactions itself.

---
 rtl/wb_efuse_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/wb_efuse_loader.sv
// Wishbone read initiator that copies NUM_WORDS eFuse words into shadow
// registers after reset and on request, exposing them as a static config bus.
module wb_efuse_loader #(
  parameter int unsigned NUM_WORDS      = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic                    wbm_we_o,
  output logic [3:0]              wbm_sel_o,
  output logic [31:0]             wbm_adr_o,
  output logic [31:0]             wbm_dat_o,
  input  logic [31:0]             wbm_dat_i,
  input  logic                    wbm_ack_i,
  output logic [32*NUM_WORDS-1:0] shadow_o,
  output logic                    valid_o,
  output logic                    busy_o,
  output logic                    error_o
);

  localparam int unsigned IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SHADOW_W = 32 * NUM_WORDS;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic                pend_q, pend_d;
  logic [SHADOW_W-1:0] shadow_q, shadow_d;
  logic                valid_q, valid_d;
  logic                error_q, error_d;
  logic                busy_q, busy_d;
  logic                cyc_q, cyc_d;
  logic [31:0]         adr_q, adr_d;

  // State and registered outputs; reset arms the automatic power-up load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      timer_q  <= '0;
      pend_q   <= 1'b1;
      shadow_q <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      busy_q   <= 1'b0;
      cyc_q    <= 1'b0;
      adr_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      timer_q  <= timer_d;
      pend_q   <= pend_d;
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      busy_q   <= busy_d;
      cyc_q    <= cyc_d;
      adr_q    <= adr_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    pend_d   = pend_q;
    shadow_d = shadow_q;
    valid_d  = valid_q;
    error_d  = error_q;

    case (state_q)
      S_IDLE: begin
        if (pend_q || start_i) begin
          state_d  = S_REQ;
          pend_d   = 1'b0;
          valid_d  = 1'b0;
          error_d  = 1'b0;
          shadow_d = '0;
          idx_d    = '0;
          timer_d  = '0;
        end
      end
      S_REQ: begin
        // An ack on the final timeout cycle still wins over the abort.
        if (wbm_ack_i) begin
          shadow_d[32*int'(idx_q) +: 32] = wbm_dat_i;
          timer_d = '0;
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_GAP;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (timer_q == TMR_LAST) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_GAP: begin
        state_d = S_REQ;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cyc_d  = (state_d == S_REQ);
    busy_d = (state_d != S_IDLE);
    adr_d  = cyc_d ? (BASE_ADDR + (32'(idx_d) << 2)) : 32'h0;
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = 32'h0;
  assign shadow_o  = shadow_q;
  assign valid_o   = valid_q;
  assign busy_o    = busy_q;
  assign error_o   = error_q;

endmodule
